// File: rtl/wb_vmon_write_snoop_pkg.sv
// Shared types and SEL decode for the vmon Wishbone write snooper.
// Turns one byte-select pattern into a right-justified event.
package vmon_wb_snoop_pkg;

    localparam logic [3:0] SEL_B0   = 4'b0001;
    localparam logic [3:0] SEL_B1   = 4'b0010;
    localparam logic [3:0] SEL_B2   = 4'b0100;
    localparam logic [3:0] SEL_B3   = 4'b1000;
    localparam logic [3:0] SEL_H0   = 4'b0011;
    localparam logic [3:0] SEL_H1   = 4'b1100;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  size;
    } vmon_ev_t;

    typedef struct packed {
        logic     valid;
        vmon_ev_t ev;
    } vmon_dec_t;

    function automatic vmon_dec_t vmon_decode(input logic [3:0] sel, input logic [31:0] dat);
        vmon_dec_t d;
        d = '0;
        d.valid = 1'b1;
        case (sel)
            SEL_B0:   begin d.ev.data = {24'h0, dat[7:0]};   d.ev.size = 3'd1; end
            SEL_B1:   begin d.ev.data = {24'h0, dat[15:8]};  d.ev.size = 3'd1; end
            SEL_B2:   begin d.ev.data = {24'h0, dat[23:16]}; d.ev.size = 3'd1; end
            SEL_B3:   begin d.ev.data = {24'h0, dat[31:24]}; d.ev.size = 3'd1; end
            SEL_H0:   begin d.ev.data = {16'h0, dat[15:0]};  d.ev.size = 3'd2; end
            SEL_H1:   begin d.ev.data = {16'h0, dat[31:16]}; d.ev.size = 3'd2; end
            SEL_WORD: begin d.ev.data = dat;                 d.ev.size = 3'd4; end
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wb_vmon_write_snoop_fifo.sv
// Event FIFO for the write snooper; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module vmon_ev_fifo
    import vmon_wb_snoop_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push,
    input  vmon_ev_t push_ev,
    output logic     full,
    input  logic     pop,
    output vmon_ev_t pop_ev,
    output logic     empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    vmon_ev_t       mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign pop_ev  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_ev;
    end

endmodule

// File: rtl/wb_vmon_write_snoop.sv
// Passive Wishbone snooper: queues acknowledged writes to one word address
// as right-justified byte events on a valid/ready stream. Never drives the bus.
module wb_vmon_write_snoop
    import vmon_wb_snoop_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] ADDRESS,
    input  logic [WB_ADDR_WIDTH-1:0] ADR,
    input  logic [WB_DATA_WIDTH-1:0] DAT_W,
    input  logic                     CYC,
    input  logic                     STB,
    input  logic                     WE,
    input  logic [3:0]               SEL,
    input  logic                     ACK,
    input  logic                     ERR,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [31:0]              ev_data,
    output logic [2:0]               ev_size,
    output logic                     ev_overflow,
    input  logic                     ovf_clr,
    output logic                     sel_err
);

    logic      addr_eq;
    logic      capture;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      push;
    logic      drop;
    logic      unused_lanes;
    vmon_dec_t dec;
    vmon_ev_t  head;

    assign addr_eq      = (ADR[WB_ADDR_WIDTH-1:2] == ADDRESS[WB_ADDR_WIDTH-1:2]);
    assign unused_lanes = ^{ADR[1:0], ADDRESS[1:0]};
    assign capture      = CYC & STB & WE & ACK & ~ERR & addr_eq & ~rst_i;
    assign dec          = vmon_decode(SEL, DAT_W);

    assign pop  = ~fifo_empty & ev_ready;
    assign push = capture & dec.valid & (~fifo_full | pop);
    assign drop = capture & dec.valid & fifo_full & ~pop;

    vmon_ev_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push),
        .push_ev (dec.ev),
        .full    (fifo_full),
        .pop     (pop),
        .pop_ev  (head),
        .empty   (fifo_empty)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_data  = fifo_empty ? '0 : head.data;
    assign ev_size  = fifo_empty ? '0 : head.size;

    // A drop in the same cycle as ovf_clr wins, so no overflow goes unreported.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ev_overflow <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            if (drop)         ev_overflow <= 1'b1;
            else if (ovf_clr) ev_overflow <= 1'b0;
            sel_err <= capture & ~dec.valid;
        end
    end

endmodule

// File: tb/tb_wb_vmon_write_snoop.sv
// Self-checking bench for wb_vmon_write_snoop: table of single bus phases
// plus hand-written overflow and mid-operation reset sequences.
module tb_wb_vmon_write_snoop;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] ADDRESS = 32'h0000_1000;
    logic [31:0] ADR = '0;
    logic [31:0] DAT_W = '0;
    logic        CYC = 1'b0, STB = 1'b0, WE = 1'b0, ACK = 1'b0, ERR = 1'b0;
    logic [3:0]  SEL = '0;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [31:0] ev_data;
    logic [2:0]  ev_size;
    logic        ev_overflow;
    logic        ovf_clr = 1'b0;
    logic        sel_err;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  size;
    } exp_t;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        cyc, stb, we, ack, err;
        logic        exp_ev;
        logic [31:0] exp_data;
        logic [2:0]  exp_size;
        logic        exp_selerr;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ev = 0;
    int   n_selerr = 0;

    wb_vmon_write_snoop #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ADDRESS     (ADDRESS),
        .ADR         (ADR),
        .DAT_W       (DAT_W),
        .CYC         (CYC),
        .STB         (STB),
        .WE          (WE),
        .SEL         (SEL),
        .ACK         (ACK),
        .ERR         (ERR),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .ev_size     (ev_size),
        .ev_overflow (ev_overflow),
        .ovf_clr     (ovf_clr),
        .sel_err     (sel_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: every handshake is matched against the oldest expected event.
    always @(negedge clk_i) begin
        if (sel_err) n_selerr++;
        if (ev_valid && ev_ready) begin
            exp_t e;
            n_ev++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got data=%h size=%0d, expected no event", ev_data, ev_size);
            end else begin
                e = exp_q.pop_front();
                chk("ev_data", ev_data, e.data);
                chk("ev_size", {29'h0, ev_size}, {29'h0, e.size});
            end
        end
    end

    // Called at posedge+1; holds the phase across exactly one rising edge.
    task automatic drive_bus(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                             input logic cyc, input logic stb, input logic we,
                             input logic ack, input logic err);
        ADR = adr; SEL = sel; DAT_W = dat;
        CYC = cyc; STB = stb; WE = we; ACK = ack; ERR = err;
        @(posedge clk_i);
        #1;
        CYC = 1'b0; STB = 1'b0; WE = 1'b0; ACK = 1'b0; ERR = 1'b0;
        SEL = '0; DAT_W = '0; ADR = '0;
    endtask

    task automatic wr(input logic [31:0] dat, input logic expect_ev);
        if (expect_ev) exp_q.push_back('{data: dat, size: 3'd4});
        drive_bus(32'h0000_1000, 4'b1111, dat, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
        chk(name, exp_q.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    vec_t vecs[16];

    initial begin
        int ev0, se0;

        vecs[0]  = '{32'h0000_1000, 4'b1111, 32'hDEADBEEF, 1,1,1,1,0, 1, 32'hDEADBEEF, 3'd4, 0};
        vecs[1]  = '{32'h0000_1003, 4'b0010, 32'h44332211, 1,1,1,1,0, 1, 32'h0000_0022, 3'd1, 0};
        vecs[2]  = '{32'h0000_1003, 4'b1000, 32'h44332211, 1,1,1,1,0, 1, 32'h0000_0044, 3'd1, 0};
        vecs[3]  = '{32'h0000_1003, 4'b1100, 32'h44332211, 1,1,1,1,0, 1, 32'h0000_4433, 3'd2, 0};
        vecs[4]  = '{32'h0000_1003, 4'b0011, 32'h44332211, 1,1,1,1,0, 1, 32'h0000_2211, 3'd2, 0};
        vecs[5]  = '{32'h0000_1002, 4'b0001, 32'h44332211, 1,1,1,1,0, 1, 32'h0000_0011, 3'd1, 0};
        vecs[6]  = '{32'h0000_1001, 4'b0100, 32'h44332211, 1,1,1,1,0, 1, 32'h0000_0033, 3'd1, 0};
        vecs[7]  = '{32'h0000_1000, 4'b1111, 32'h12345678, 1,1,0,1,0, 0, 32'h0, 3'd0, 0};
        vecs[8]  = '{32'h0000_1004, 4'b1111, 32'h12345678, 1,1,1,1,0, 0, 32'h0, 3'd0, 0};
        vecs[9]  = '{32'h0000_1000, 4'b1111, 32'h12345678, 1,1,1,0,1, 0, 32'h0, 3'd0, 0};
        vecs[10] = '{32'h0000_1000, 4'b1111, 32'h12345678, 1,1,1,0,0, 0, 32'h0, 3'd0, 0};
        vecs[11] = '{32'h0000_1000, 4'b1111, 32'h12345678, 1,1,1,1,1, 0, 32'h0, 3'd0, 0};
        vecs[12] = '{32'h0000_1000, 4'b0101, 32'h12345678, 1,1,1,1,0, 0, 32'h0, 3'd0, 1};
        vecs[13] = '{32'h0000_1000, 4'b0000, 32'h12345678, 1,1,1,1,0, 0, 32'h0, 3'd0, 1};
        vecs[14] = '{32'h0000_1000, 4'b1111, 32'h12345678, 0,1,1,1,0, 0, 32'h0, 3'd0, 0};
        vecs[15] = '{32'h8000_1000, 4'b1111, 32'h12345678, 1,1,1,1,0, 0, 32'h0, 3'd0, 0};

        #2;
        chk("rst_ev_valid", {31'h0, ev_valid}, 0);
        chk("rst_ev_data", ev_data, 0);
        chk("rst_ev_size", {29'h0, ev_size}, 0);
        chk("rst_ev_overflow", {31'h0, ev_overflow}, 0);
        chk("rst_sel_err", {31'h0, sel_err}, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        ev_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ev0 = n_ev;
            se0 = n_selerr;
            if (vecs[i].exp_ev) exp_q.push_back('{data: vecs[i].exp_data, size: vecs[i].exp_size});
            drive_bus(vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].cyc, vecs[i].stb,
                      vecs[i].we, vecs[i].ack, vecs[i].err);
            repeat (2) @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d_events", i), n_ev - ev0, {31'h0, vecs[i].exp_ev});
            chk($sformatf("vec%0d_sel_err", i), n_selerr - se0, {31'h0, vecs[i].exp_selerr});
        end

        // Overflow: six writes into a stalled depth-4 queue.
        ev_ready = 1'b0;
        ev0 = n_ev;
        for (int d = 1; d <= 6; d++) wr(d, d <= 4);
        chk("ovf_set", {31'h0, ev_overflow}, 1);
        chk("stall_valid", {31'h0, ev_valid}, 1);
        chk("stall_head", ev_data, 1);
        @(posedge clk_i);
        #1;
        chk("stall_hold", ev_data, 1);
        ev_ready = 1'b1;
        drain("drain_a");
        chk("drain_a_count", n_ev - ev0, 4);
        chk("drain_a_empty", {31'h0, ev_valid}, 0);
        chk("ovf_sticky", {31'h0, ev_overflow}, 1);
        ovf_clr = 1'b1;
        @(posedge clk_i);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", {31'h0, ev_overflow}, 0);

        // Drop coinciding with ovf_clr, then a capture into a full queue with a pop.
        ev_ready = 1'b0;
        ev0 = n_ev;
        for (int d = 0; d < 4; d++) wr(32'hA1 + d, 1'b1);
        ovf_clr = 1'b1;
        wr(32'hA5, 1'b0);
        ovf_clr = 1'b0;
        chk("ovf_clr_vs_drop", {31'h0, ev_overflow}, 1);
        ev_ready = 1'b1;
        wr(32'hA6, 1'b1);
        drain("drain_b");
        chk("drain_b_count", n_ev - ev0, 5);

        // Asynchronous reset between edges with three events queued.
        ev_ready = 1'b0;
        for (int d = 0; d < 3; d++) wr(32'h11 * (d + 1), 1'b1);
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", {31'h0, ev_valid}, 0);
        chk("async_rst_data", ev_data, 0);
        exp_q.delete();
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        chk("post_rst_empty", {31'h0, ev_valid}, 0);
        chk("post_rst_ovf", {31'h0, ev_overflow}, 0);
        ev_ready = 1'b1;
        ev0 = n_ev;
        wr(32'h55, 1'b1);
        drain("drain_c");
        chk("drain_c_count", n_ev - ev0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_vmon_write_snoop.md
Name: wb_vmon_write_snoop

Overview:
- Passive Wishbone write snooper for the vmon host-messaging channel.
- Watches a Wishbone B3/B4 classic bus for acknowledged writes to one configurable word address.
- Extracts the written bytes, right-justified, plus a byte count.
- Queues each event in a small FIFO and presents it on a valid/ready stream toward the vmon host-bridge logic.
- Never drives the bus.

Parameters:
- WB_ADDR_WIDTH, 32: Wishbone byte-address width.
- WB_DATA_WIDTH, 32: Wishbone data width. Only 32 is supported; SEL is 4 bits.
- FIFO_DEPTH, 4: number of event entries. Must be a power of two, ≥2.

Ports:
- clk_i, in, 1: bus clock. All logic is on the rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- ADDRESS, in, WB_ADDR_WIDTH: monitored byte address. Quasi-static.
- ADR, in, WB_ADDR_WIDTH: bus address.
- DAT_W, in, WB_DATA_WIDTH: master write data.
- CYC, in, 1: bus cycle.
- STB, in, 1: strobe.
- WE, in, 1: write enable.
- SEL, in, 4: byte selects.
- ACK, in, 1: slave acknowledge.
- ERR, in, 1: slave error.
- ev_valid, out, 1: event available.
- ev_ready, in, 1: consumer accepts the event.
- ev_data, out, 32: event data, right-justified and zero-extended.
- ev_size, out, 3: event byte count (1, 2 or 4).
- ev_overflow, out, 1: sticky flag; an event was dropped because the FIFO was full.
- ovf_clr, in, 1: synchronous clear of ev_overflow.
- sel_err, out, 1: one-cycle pulse on a matched write with an unsupported SEL.

Behaviour:
- Reset:
  - While rst_i is high, the FIFO is empty.
  - ev_valid, ev_overflow and sel_err are 0.
  - ev_data and ev_size are 0.
  - Reset applied mid-operation discards all queued events immediately.
- Address match:
  - addr_eq is true when ADR[WB_ADDR_WIDTH-1:2] equals ADDRESS[WB_ADDR_WIDTH-1:2].
  - The byte-lane bits [1:0] are ignored.
- Capture condition, sampled at the rising edge: CYC & STB & WE & ACK & ~ERR & addr_eq & ~rst_i.
  - Reads, unacknowledged phases and error-terminated phases never capture.
  - Each ACK cycle is one capture. Back-to-back ACKs give back-to-back events.
- SEL decode on capture:
  - 0001: data = DAT_W[7:0], size 1.
  - 0010: data = DAT_W[15:8], size 1.
  - 0100: data = DAT_W[23:16], size 1.
  - 1000: data = DAT_W[31:24], size 1.
  - 0011: data = DAT_W[15:0], size 2.
  - 1100: data = DAT_W[31:16], size 2.
  - 1111: data = DAT_W[31:0], size 4.
  - Any other SEL, including 0000: no event is queued; sel_err pulses high for exactly the next cycle.
- Queueing:
  - A decoded event is written into the FIFO at the capture edge.
  - ev_valid rises in the cycle after the capture edge (1-cycle latency).
  - ev_data and ev_size show the FIFO head whenever ev_valid is 1.
  - ev_data and ev_size are held stable while ev_valid=1 and ev_ready=0.
- Pop: on any edge where ev_valid and ev_ready are both 1.
- Ordering: strict FIFO order.
- Full FIFO:
  - A capture with a simultaneous pop is accepted.
  - A capture without a pop drops the new event and sets ev_overflow. Existing entries are unchanged.
- ev_overflow:
  - Stays set until rst_i or ovf_clr.
  - If ovf_clr and a new drop occur in the same cycle, the flag stays 1.
- Empty FIFO with ev_ready=1: no effect.
- Pointers wrap modulo FIFO_DEPTH.
- Occupancy uses an extra bit to distinguish full from empty.

Decomposition:
- Package vmon_wb_snoop_pkg:
  - Constants for the SEL codes.
  - typedef vmon_ev_t as a packed struct {logic [31:0] data; logic [2:0] size;}.
  - A decode function mapping (SEL, DAT_W) to {valid, vmon_ev_t}.
- Sub-module vmon_ev_fifo: synchronous FIFO of vmon_ev_t, parameterised by FIFO_DEPTH, async active-high reset, with push/full/pop/empty ports.
- The top level holds the match and decode logic, the overflow flag and the sel_err flop.

Test Plan:
- ADDRESS=0x1000, write ADR=0x1000, SEL=1111, DAT_W=0xDEADBEEF, ACK, ev_ready=1 -> one event, data 0xDEADBEEF, size 4, ev_valid high for one cycle.
- SEL sweep at ADR=0x1003, DAT_W=0x44332211:
  - 0010 -> 0x22, size 1.
  - 1000 -> 0x44, size 1.
  - 1100 -> 0x4433, size 2.
  - 0011 -> 0x2211, size 2.
- Non-captures -> no events:
  - Read with ADR=0x1000.
  - Write to 0x1004.
  - Write with ERR=1 and ACK=0.
  - Write with STB but no ACK.
- SEL=0101 write to 0x1000 -> sel_err single pulse, no event.
- FIFO_DEPTH=4, ev_ready=0, six writes with data 1..6 -> queue holds 1..4 and ev_overflow=1. Then ev_ready=1 -> 1, 2, 3, 4 drain in order. ovf_clr -> ev_overflow=0.
- Three events queued, assert rst_i asynchronously between edges -> ev_valid drops immediately. After release the FIFO is empty.
